// File: rtl/sound_effect_player.sv
// Sound effect sequencer: a valid event strobe starts a 2-3 note melody of square
// waves on the buzzer pin, each note followed by a silent gap.
module sound_effect_player #(
   parameter int M        = 2,
   parameter int CNT_W    = 24,
   parameter int NOTE_LEN = 10_000_000,
   parameter int GAP_LEN  = 1_000_000,
   parameter int HP_C     = 191_110,
   parameter int HP_E     = 151_685,
   parameter int HP_G     = 127_551
) (
   input  logic         clk,
   input  logic         reset_global_n,
   input  logic [M-1:0] sound_event_code_in,
   input  logic         sound_trigger_in,
   input  logic         sound_enable_in,
   output logic         buzzer_out,
   output logic         busy_out,
   output logic         done_pulse_out
);

   typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
   localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(HP_C - 1);
   localparam logic [CNT_W-1:0] E_LAST    = CNT_W'(HP_E - 1);
   localparam logic [CNT_W-1:0] G_LAST    = CNT_W'(HP_G - 1);
   localparam logic [M-1:0]     CODE_NONE = '0;
   localparam logic [M-1:0]     CODE_EAT  = M'(1);
   localparam logic [M-1:0]     CODE_OVER = M'(2);

   state_t           state_q, state_d;
   logic [M-1:0]     code_q, code_d;
   logic [1:0]       note_idx_q, note_idx_d;
   logic [CNT_W-1:0] tone_cnt_q, tone_cnt_d;
   logic [CNT_W-1:0] len_cnt_q, len_cnt_d;
   logic             square_q, square_d;
   logic             buzzer_q, buzzer_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [CNT_W-1:0] hp_last;
   logic [1:0]       last_idx;
   logic             valid_trig;

   // Melody ROM: terminal tone count of the current note.
   always_comb begin
      hp_last = C_LAST;
      if (code_q == CODE_EAT) begin
         hp_last = (note_idx_q == 2'd0) ? E_LAST : G_LAST;
      end else if (code_q == CODE_OVER) begin
         case (note_idx_q)
            2'd0:    hp_last = G_LAST;
            2'd1:    hp_last = E_LAST;
            default: hp_last = C_LAST;
         endcase
      end else begin
         case (note_idx_q)
            2'd0:    hp_last = C_LAST;
            2'd1:    hp_last = E_LAST;
            default: hp_last = G_LAST;
         endcase
      end
   end

   assign last_idx   = (code_q == CODE_EAT) ? 2'd1 : 2'd2;
   assign valid_trig = sound_trigger_in && (sound_event_code_in != CODE_NONE);

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      note_idx_d = note_idx_q;
      tone_cnt_d = tone_cnt_q;
      len_cnt_d  = len_cnt_q;
      square_d   = square_q;
      busy_d     = busy_q;
      buzzer_d   = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         TONE: begin
            len_cnt_d = len_cnt_q + CNT_ONE;
            if (tone_cnt_q == hp_last) begin
               tone_cnt_d = '0;
               square_d   = ~square_q;
            end else begin
               tone_cnt_d = tone_cnt_q + CNT_ONE;
            end
            buzzer_d = square_d & sound_enable_in;
            if (len_cnt_q == NOTE_LAST) begin
               state_d    = GAP;
               len_cnt_d  = '0;
               tone_cnt_d = '0;
               square_d   = 1'b0;
               buzzer_d   = 1'b0;
            end
         end
         GAP: begin
            if (len_cnt_q == GAP_LAST) begin
               len_cnt_d = '0;
               if (note_idx_q == last_idx) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  note_idx_d = note_idx_q + 2'd1;
                  tone_cnt_d = '0;
                  state_d    = TONE;
               end
            end else begin
               len_cnt_d = len_cnt_q + CNT_ONE;
            end
         end
         default: busy_d = 1'b0;
      endcase

      // A new event pre-empts whatever is playing, even on the completion edge.
      if (valid_trig) begin
         code_d     = sound_event_code_in;
         note_idx_d = 2'd0;
         tone_cnt_d = '0;
         len_cnt_d  = '0;
         square_d   = 1'b0;
         state_d    = TONE;
         busy_d     = 1'b1;
         buzzer_d   = 1'b0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_global_n) begin
      if (!reset_global_n) begin
         state_q    <= IDLE;
         code_q     <= '0;
         note_idx_q <= 2'd0;
         tone_cnt_q <= '0;
         len_cnt_q  <= '0;
         square_q   <= 1'b0;
         buzzer_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         note_idx_q <= note_idx_d;
         tone_cnt_q <= tone_cnt_d;
         len_cnt_q  <= len_cnt_d;
         square_q   <= square_d;
         buzzer_q   <= buzzer_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign buzzer_out     = buzzer_q;
   assign busy_out       = busy_q;
   assign done_pulse_out = done_q;

endmodule

// File: tb/tb_sound_effect_player.sv
// Bench for sound_effect_player: directed scenarios plus random events, checked every
// cycle against a timeline model of the melodies.
module tb_sound_effect_player;

   localparam int NOTE_LEN = 20;
   localparam int GAP_LEN  = 4;
   localparam int SLOT     = NOTE_LEN + GAP_LEN;

   logic       clk = 1'b0;
   logic       reset_global_n;
   logic [1:0] sound_event_code_in;
   logic       sound_trigger_in;
   logic       sound_enable_in;
   logic       buzzer_out;
   logic       busy_out;
   logic       done_pulse_out;

   int         n_checks = 0;
   int         n_bad = 0;
   logic [2:0] exp_q[$];
   int         m_active = 0;
   int         m_code = 0;
   int         m_k = 0;
   int         done_seen = 0;

   sound_effect_player #(
      .M(2), .CNT_W(8), .NOTE_LEN(NOTE_LEN), .GAP_LEN(GAP_LEN),
      .HP_C(5), .HP_E(4), .HP_G(3)
   ) dut (
      .clk                 (clk),
      .reset_global_n      (reset_global_n),
      .sound_event_code_in (sound_event_code_in),
      .sound_trigger_in    (sound_trigger_in),
      .sound_enable_in     (sound_enable_in),
      .buzzer_out          (buzzer_out),
      .busy_out            (busy_out),
      .done_pulse_out      (done_pulse_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Half period of note n of a melody: 01 = E,G; 10 = G,E,C; 11 = C,E,G.
   function automatic int hp_of(input int code, input int n);
      case (code)
         1:       return (n == 0) ? 4 : 3;
         2:       return (n == 0) ? 3 : (n == 1) ? 4 : 5;
         default: return (n == 0) ? 5 : (n == 1) ? 4 : 3;
      endcase
   endfunction

   // Expected outputs after one clock edge, from time elapsed since the accept edge.
   task automatic model_edge(input logic trig, input logic [1:0] code, input logic en);
      int   total, p, hp;
      logic b, d, z;
      if (trig && code != 2'd0) begin
         m_active = 1;
         m_code   = code;
         m_k      = 0;
      end else if (m_active != 0) begin
         m_k++;
      end
      total = ((m_code == 1) ? 2 : 3) * SLOT;
      if (m_active != 0 && m_k > total) m_active = 0;
      b = (m_active != 0) && (m_k < total);
      d = (m_active != 0) && (m_k == total);
      z = 1'b0;
      if (b) begin
         p  = m_k % SLOT;
         hp = hp_of(m_code, m_k / SLOT);
         z  = (p >= 1) && (p < NOTE_LEN) && ((p / hp) % 2 == 1) && en;
      end
      exp_q.push_back({b, d, z});
   endtask

   task automatic step(input logic trig, input logic [1:0] code, input logic en);
      logic [2:0] e;
      @(negedge clk);
      sound_trigger_in    = trig;
      sound_event_code_in = code;
      sound_enable_in     = en;
      @(posedge clk);
      model_edge(trig, code, en);
      #1;
      sound_trigger_in = 1'b0;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("busy", busy_out, e[2]);
         check("done", done_pulse_out, e[1]);
         check("buzzer", buzzer_out, e[0]);
      end
      if (done_pulse_out) done_seen++;
   endtask

   task automatic idle_steps(input int n, input logic en);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, en);
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_global_n   = 1'b0;
      sound_trigger_in = 1'b0;
      #1;
      check("rst_busy", busy_out, 1'b0);
      check("rst_done", done_pulse_out, 1'b0);
      check("rst_buzzer", buzzer_out, 1'b0);
      m_active = 0;
      @(posedge clk);
      @(negedge clk);
      reset_global_n = 1'b1;
   endtask

   initial begin
      reset_global_n      = 1'b1;
      sound_event_code_in = 2'd0;
      sound_trigger_in    = 1'b0;
      sound_enable_in     = 1'b1;
      do_reset();
      idle_steps(3, 1'b1);

      // EAT melody, audible
      done_seen = 0;
      step(1'b1, 2'd1, 1'b1);
      idle_steps(55, 1'b1);
      check("eat_done_count", done_seen, 1);

      // code 00 strobe is ignored
      step(1'b1, 2'd0, 1'b1);
      idle_steps(10, 1'b1);

      // EAT pre-empted by GAME_OVER after 10 cycles
      done_seen = 0;
      step(1'b1, 2'd1, 1'b1);
      idle_steps(9, 1'b1);
      step(1'b1, 2'd2, 1'b1);
      idle_steps(78, 1'b1);
      check("preempt_done_count", done_seen, 1);

      // GAME_START muted
      step(1'b1, 2'd3, 1'b0);
      idle_steps(78, 1'b0);

      // mute toggled mid-note
      step(1'b1, 2'd2, 1'b1);
      for (int i = 0; i < 76; i++) step(1'b0, 2'd0, ((i / 7) % 2) == 0);

      // reset during note 2 of GAME_START, then a normal EAT
      done_seen = 0;
      step(1'b1, 2'd3, 1'b1);
      idle_steps(29, 1'b1);
      do_reset();
      idle_steps(8, 1'b1);
      check("reset_no_done", done_seen, 0);
      step(1'b1, 2'd1, 1'b1);
      idle_steps(55, 1'b1);

      // trigger on the completion edge wins over done
      done_seen = 0;
      step(1'b1, 2'd1, 1'b1);
      idle_steps(47, 1'b1);
      step(1'b1, 2'd3, 1'b1);
      idle_steps(78, 1'b1);
      check("same_cycle_done_count", done_seen, 1);

      // random event storm
      begin
         logic en;
         en = 1'b1;
         for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            step($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), en);
         end
      end
      idle_steps(80, 1'b1);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
